mvu_job_responder: RTL and testbench

Per-channel job handshake engine between the pito harts and the MVU array. It accepts job-launch commands issued by pito firmware and emits a single-cycle start pulse to the addressed MVU. It then tracks that MVU until it reports completion or a watchdog expires, and holds a pending interrupt back to the hart until the hart acknowledges it. It is the responder end of the pito→MVU job protocol and sits between pito's CSR/command path and the MVU start/done/irq wiring inside barvinn.

---
 rtl/mvu_job_responder_if.sv | 26 ++
 rtl/mvu_job_responder.sv | 114 +++++++++++
 tb/tb_mvu_job_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mvu_job_responder_if.sv
// rtl/mvu_job_responder_if.sv - pito/MVU job handshake bundle for mvu_job_responder
interface mvu_job_responder_if #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic              cmd_valid;
    logic [CH_W-1:0]   cmd_ch;
    logic              cmd_ready;
    logic [NUM_CH-1:0] mvu_start;
    logic [NUM_CH-1:0] mvu_done;
    logic [NUM_CH-1:0] irq;
    logic [NUM_CH-1:0] irq_ack;
    logic [NUM_CH-1:0] irq_timeout;
    logic [NUM_CH-1:0] busy;

    // master is the pito/MVU side, slave is the responder
    modport master (
        output cmd_valid, cmd_ch, mvu_done, irq_ack,
        input  cmd_ready, mvu_start, irq, irq_timeout, busy
    );

    modport slave (
        input  cmd_valid, cmd_ch, mvu_done, irq_ack,
        output cmd_ready, mvu_start, irq, irq_timeout, busy
    );
endinterface

// File: rtl/mvu_job_responder.sv
// rtl/mvu_job_responder.sv - per-channel job launch, watchdog and pending-irq engine
module mvu_job_responder #(
    parameter int NUM_CH  = 8,
    parameter int CH_W    = $clog2(NUM_CH),
    parameter int TIMEOUT = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mvu_job_responder_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_PEND = 2'd2
    } state_t;

    // counter is 0 in the first BUSY cycle, so expiry is seen at TIMEOUT-1
    localparam logic [23:0] CNT_LAST = 24'(TIMEOUT - 1);

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [23:0]       cnt_q   [NUM_CH];
    logic [23:0]       cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] start_d, start_q;
    logic [NUM_CH-1:0] busy_d,  busy_q;
    logic [NUM_CH-1:0] irq_d,   irq_q;
    logic [NUM_CH-1:0] tmo_d,   tmo_q;
    logic              ch_idle;

    // an out-of-range cmd_ch matches no channel, so it is never ready
    always_comb begin
        ch_idle = 1'b0;
        accept  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cmd_ch == CH_W'(i) && state_q[i] == S_IDLE) begin
                ch_idle   = 1'b1;
                accept[i] = bus.cmd_valid;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            tmo_d[i]   = tmo_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (accept[i]) begin
                        state_d[i] = S_BUSY;
                        cnt_d[i]   = '0;
                        tmo_d[i]   = 1'b0;
                    end
                end
                S_BUSY: begin
                    cnt_d[i] = cnt_q[i] + 24'd1;
                    // done takes priority over a coincident expiry
                    if (bus.mvu_done[i]) begin
                        state_d[i] = S_PEND;
                        tmo_d[i]   = 1'b0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_PEND;
                        tmo_d[i]   = 1'b1;
                    end
                end
                S_PEND: begin
                    if (bus.irq_ack[i]) begin
                        state_d[i] = S_IDLE;
                        tmo_d[i]   = 1'b0;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    tmo_d[i]   = 1'b0;
                end
            endcase
            start_d[i] = accept[i];
            busy_d[i]  = (state_d[i] == S_BUSY);
            irq_d[i]   = (state_d[i] == S_PEND);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            start_q <= '0;
            busy_q  <= '0;
            irq_q   <= '0;
            tmo_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            start_q <= start_d;
            busy_q  <= busy_d;
            irq_q   <= irq_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.cmd_ready   = ch_idle;
    assign bus.mvu_start   = start_q;
    assign bus.busy        = busy_q;
    assign bus.irq         = irq_q;
    assign bus.irq_timeout = tmo_q;

endmodule

// File: tb/tb_mvu_job_responder.sv
// tb/tb_mvu_job_responder.sv - scoreboard bench for mvu_job_responder
module tb_mvu_job_responder;

    localparam int NUM_CH  = 8;
    localparam int CH_W    = 4;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int kind;   // 0 = start pulse, 1 = irq rise
        int ch;
        int tmo;
        int cyc;
    } ev_t;

    ev_t               exp_q[$];
    logic [NUM_CH-1:0] irq_prev = '0;

    mvu_job_responder_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    mvu_job_responder #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int ch, input int tmo, input int at);
        ev_t e;
        e.kind = kind; e.ch = ch; e.tmo = tmo; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input int kind, input int ch, input int tmo);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d ch %0d tmo %0d at cycle %0d, expected none",
                     kind, ch, tmo, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_ch",   32'(ch),   32'(e.ch));
            chk("event_tmo",  32'(tmo),  32'(e.tmo));
            chk("event_cyc",  32'(cyc),  32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.mvu_start[c]) sb_check(0, c, 0);
                if (bus.irq[c] && !irq_prev[c]) sb_check(1, c, int'(bus.irq_timeout[c]));
            end
        end
        irq_prev = bus.irq;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int ch, input bit exp_ready, output int acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = CH_W'(ch);
        #1;
        chk($sformatf("cmd_ready_ch%0d", ch), 32'(bus.cmd_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        acc = cyc;
        if (exp_ready) push_ev(0, ch, 0, acc);
    endtask

    task automatic do_done(input int ch, input int tmo);
        bus.mvu_done[ch] = 1'b1;
        push_ev(1, ch, tmo, cyc + 1);
        step();
        bus.mvu_done[ch] = 1'b0;
    endtask

    task automatic do_ack(input int ch);
        bus.irq_ack[ch] = 1'b1;
        step();
        bus.irq_ack[ch] = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(bus.mvu_start),   32'h0);
        chk({tag, "_busy"},  32'(bus.busy),        32'h0);
        chk({tag, "_irq"},   32'(bus.irq),         32'h0);
        chk({tag, "_tmo"},   32'(bus.irq_timeout), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        bus.cmd_valid = 1'b0;
        bus.cmd_ch    = '0;
        bus.mvu_done  = '0;
        bus.irq_ack   = '0;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        step();
        step();
        rst_n = 1'b1;

        // basic job on ch 3, done 10 cycles after acceptance
        launch(3, 1'b1, acc);
        for (int k = 0; k < 9; k++) begin
            chk("basic_busy3", 32'(bus.busy[3]), 32'h1);
            step();
        end
        chk("basic_busy3_last", 32'(bus.busy[3]), 32'h1);
        do_done(3, 0);
        chk("basic_busy3_off", 32'(bus.busy[3]), 32'h0);
        chk("basic_irq3", 32'(bus.irq[3]), 32'h1);
        chk("basic_tmo3", 32'(bus.irq_timeout[3]), 32'h0);
        do_ack(3);
        chk("basic_irq3_clr", 32'(bus.irq[3]), 32'h0);
        // relaunch and finish in the start cycle
        launch(3, 1'b1, acc);
        do_done(3, 0);
        do_ack(3);

        // back-pressure on ch 5, ch 6 still accepted
        launch(5, 1'b1, acc);
        launch(5, 1'b0, acc);
        launch(5, 1'b0, acc);
        launch(6, 1'b1, acc);
        chk("bp_busy", 32'(bus.busy), 32'h60);
        do_done(5, 0);
        do_done(6, 0);
        do_ack(5);
        do_ack(6);

        // watchdog on ch 0
        launch(0, 1'b1, acc);
        push_ev(1, 0, 1, acc + TIMEOUT);
        repeat (TIMEOUT - 1) step();
        chk("wd_irq0_early", 32'(bus.irq[0]), 32'h0);
        step();
        chk("wd_irq0", 32'(bus.irq[0]), 32'h1);
        chk("wd_tmo0", 32'(bus.irq_timeout[0]), 32'h1);
        chk("wd_busy0", 32'(bus.busy[0]), 32'h0);
        bus.mvu_done[0] = 1'b1;
        step();
        bus.mvu_done[0] = 1'b0;
        chk("wd_late_irq0", 32'(bus.irq[0]), 32'h1);
        chk("wd_late_tmo0", 32'(bus.irq_timeout[0]), 32'h1);
        do_ack(0);
        chk("wd_ack_tmo0", 32'(bus.irq_timeout[0]), 32'h0);

        // done coincides with counter == TIMEOUT-1
        launch(1, 1'b1, acc);
        repeat (TIMEOUT - 1) step();
        do_done(1, 0);
        chk("race_tmo1", 32'(bus.irq_timeout[1]), 32'h0);
        do_ack(1);

        // stray events on idle ch 2 and an out-of-range channel
        bus.mvu_done[2] = 1'b1;
        bus.irq_ack[2]  = 1'b1;
        step();
        bus.mvu_done[2] = 1'b0;
        bus.irq_ack[2]  = 1'b0;
        step();
        chk("stray_irq", 32'(bus.irq), 32'h0);
        chk("stray_busy", 32'(bus.busy), 32'h0);
        launch(9, 1'b0, acc);
        step();
        chk("stray_busy_ch9", 32'(bus.busy), 32'h0);

        // reset in the middle of eight jobs
        for (int c = 0; c < NUM_CH; c++) launch(c, 1'b1, acc);
        step();
        chk("mid_busy_all", 32'(bus.busy), 32'hff);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        step();
        rst_n = 1'b1;
        bus.mvu_done = '1;
        step();
        bus.mvu_done = '0;
        step();
        chk_all_zero("post_reset");
        for (int c = 0; c < NUM_CH; c++) launch(c, 1'b1, acc);
        bus.mvu_done = '1;
        for (int c = 0; c < NUM_CH; c++) push_ev(1, c, 0, cyc + 1);
        step();
        bus.mvu_done = '0;
        chk("post_irq_all", 32'(bus.irq), 32'hff);
        bus.irq_ack = '1;
        step();
        bus.irq_ack = '0;
        chk("post_ack_irq", 32'(bus.irq), 32'h0);

        repeat (3) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
